// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes opcode(+argument) frames from the RX FIFO and serialises
// words into the TX FIFO. Optional inter-byte RX timeout is enabled by UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx_empty,
  input  logic [DATA_BITS-1:0]            r_data,
  output logic                            rd_uart,
  input  logic                            tx_full,
  output logic                            wr_uart,
  output logic [DATA_BITS-1:0]            w_data,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [DATA_BITS-1:0]            cmd_code,
  output logic [DATA_BITS*WORD_BYTES-1:0] cmd_arg,
  input  logic                            tx_word_valid,
  output logic                            tx_word_ready,
  input  logic [DATA_BITS*WORD_BYTES-1:0] tx_word,
  output logic                            rx_timeout
);

  localparam int unsigned CntW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned WordW = DATA_BITS * WORD_BYTES;
  localparam logic [CntW-1:0] LastIdx = CntW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_ARG, RX_HOLD} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [DATA_BITS-1:0] cmd_code_q, cmd_code_d;
  logic [WordW-1:0]     cmd_arg_q, cmd_arg_d;
  logic                 rx_pop;
  logic                 rx_abort;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [WordW-1:0]     tx_word_q, tx_word_d;

  // Reset gates every pop/push so nothing leaves or enters the FIFOs while held.
  assign rx_pop    = ~reset & ~rx_empty & ((rx_state_q == RX_IDLE) || (rx_state_q == RX_ARG));
  assign rd_uart   = rx_pop;
  assign cmd_valid = ~reset & (rx_state_q == RX_HOLD);
  assign cmd_code  = cmd_code_q;
  assign cmd_arg   = cmd_arg_q;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TimW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimW-1:0] TimLast = TimW'(TIMEOUT_CYCLES - 1);

  logic [TimW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    rx_abort = 1'b0;
    if ((rx_state_q == RX_ARG) && !rx_pop) begin
      if (to_cnt_q == TimLast) begin
        rx_abort = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign rx_timeout = rx_abort & ~reset;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign rx_abort   = 1'b0;
  assign rx_timeout = 1'b0;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    cmd_code_d = cmd_code_q;
    cmd_arg_d  = cmd_arg_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_pop) begin
          cmd_code_d = r_data;
          cmd_arg_d  = '0;
          rx_cnt_d   = '0;
          rx_state_d = r_data[DATA_BITS-1] ? RX_ARG : RX_HOLD;
        end
      end
      RX_ARG: begin
        if (rx_pop) begin
          for (int unsigned k = 0; k < WORD_BYTES; k++) begin
            if (rx_cnt_q == CntW'(k)) cmd_arg_d[k*DATA_BITS +: DATA_BITS] = r_data;
          end
          if (rx_cnt_q == LastIdx) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_HOLD;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end else if (rx_abort) begin
          cmd_arg_d  = '0;
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end
      end
      RX_HOLD: begin
        if (cmd_ready) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign tx_word_ready = (tx_state_q == TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_word_d  = tx_word_q;
    wr_uart    = 1'b0;
    w_data     = '0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_word_valid) begin
          tx_word_d  = tx_word;
          tx_cnt_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
          if (tx_cnt_q == CntW'(k)) w_data = tx_word_q[k*DATA_BITS +: DATA_BITS];
        end
        if (!tx_full && !reset) begin
          wr_uart = 1'b1;
          if (tx_cnt_q == LastIdx) begin
            tx_cnt_d   = '0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (reset) w_data = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      cmd_code_q <= '0;
      cmd_arg_q  <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_word_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      cmd_code_q <= cmd_code_d;
      cmd_arg_q  <= cmd_arg_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_word_q  <= tx_word_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: vector tables plus scoreboards for commands and TX bytes.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;
  localparam int unsigned DB = 8;
  localparam int unsigned WB = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_empty;
  logic [DB-1:0] r_data;
  logic          rd_uart;
  logic          tx_full;
  logic          wr_uart;
  logic [DB-1:0] w_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DB-1:0] cmd_code;
  logic [31:0]   cmd_arg;
  logic          tx_word_valid;
  logic          tx_word_ready;
  logic [31:0]   tx_word;
  logic          rx_timeout;

  uart_cmd_ctrl #(.DATA_BITS(DB), .WORD_BYTES(WB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
    .tx_word_valid(tx_word_valid), .tx_word_ready(tx_word_ready), .tx_word(tx_word),
    .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned tx_push_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RX FIFO model: pops on rd_uart sampled at the edge, head refreshed shortly after.
  logic [7:0] rx_fifo[$];
  initial begin : rx_fifo_model
    logic pop_now;
    rx_empty = 1'b1;
    r_data   = '0;
    forever begin
      @(posedge clk);
      pop_now = rd_uart;
      #1;
      if (pop_now) begin
        if (rx_fifo.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rx_pop_empty: rd_uart=1 with empty FIFO (cycle %0d)", cyc);
        end else begin
          void'(rx_fifo.pop_front());
        end
      end
      #1;
      rx_empty = (rx_fifo.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_fifo[0];
    end
  end

  typedef struct packed {logic [7:0] code; logic [31:0] arg;} cmd_t;
  cmd_t       rx_exp[$];
  logic [7:0] tx_exp[$];
  cmd_t       rx_e;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      if (rx_exp.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL cmd_unexpected: got code %0h arg %0h, none expected", cmd_code, cmd_arg);
      end else begin
        rx_e = rx_exp.pop_front();
        check("cmd_code", cmd_code, rx_e.code);
        check("cmd_arg", cmd_arg, rx_e.arg);
      end
    end
    if (wr_uart) begin
      tx_push_cnt++;
      if (tx_exp.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL tx_unexpected: got w_data %0h, none expected", w_data);
      end else begin
        check("w_data", w_data, tx_exp.pop_front());
      end
    end
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] arg;
    logic [7:0]  exp_code;
    logic [31:0] exp_arg;
  } rx_vec_t;

  typedef struct {
    logic [31:0]     word;
    logic [3:0][7:0] exp_b;  // index 0 is the first byte on the wire
  } tx_vec_t;

  rx_vec_t rx_vecs[6];
  tx_vec_t tx_vecs[4];

  task automatic push_bytes(input logic [7:0] op, input logic [31:0] arg, input logic with_arg);
    rx_fifo.push_back(op);
    if (with_arg) begin
      for (int i = 0; i < 4; i++) rx_fifo.push_back(arg[i*8 +: 8]);
    end
  endtask

  task automatic send_cmd(input rx_vec_t v);
    push_bytes(v.op, v.arg, v.op[7]);
    rx_exp.push_back({v.exp_code, v.exp_arg});
  endtask

  task automatic wait_rx_drain(input string name);
    int n = 0;
    while ((rx_exp.size() != 0 || rx_fifo.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    check(name, (n < 100), 1'b1);
  endtask

  task automatic wait_cmd_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_valid && n < 50);
    check(name, cmd_valid, 1'b1);
  endtask

  task automatic send_word(input tx_vec_t v);
    int n = 0;
    tx_word       = v.word;
    tx_word_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_word_ready && n < 50);
    check("tx_accept", tx_word_ready, 1'b1);
    for (int i = 0; i < 4; i++) tx_exp.push_back(v.exp_b[i]);
    tick();
    tx_word_valid = 1'b0;
  endtask

  task automatic wait_tx_drain(input string name);
    int n = 0;
    while ((tx_exp.size() != 0 || !tx_word_ready) && n < 100) begin
      tick();
      n++;
    end
    check(name, (n < 100), 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_uart"}, rd_uart, 1'b0);
    check({tag, "_wr_uart"}, wr_uart, 1'b0);
    check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
    check({tag, "_rx_timeout"}, rx_timeout, 1'b0);
    check({tag, "_w_data"}, w_data, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int t;
    int pulses;
    int bad;
    int push0;

    rx_vecs[0] = '{8'h05, 32'hFFFF_FFFF, 8'h05, 32'h0000_0000};
    rx_vecs[1] = '{8'h81, 32'h1234_5678, 8'h81, 32'h1234_5678};
    rx_vecs[2] = '{8'h7F, 32'h0000_AAAA, 8'h7F, 32'h0000_0000};
    rx_vecs[3] = '{8'hFF, 32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFF};
    rx_vecs[4] = '{8'h80, 32'h0000_0001, 8'h80, 32'h0000_0001};
    rx_vecs[5] = '{8'h00, 32'h0000_0000, 8'h00, 32'h0000_0000};
    tx_vecs[0] = '{32'hDEAD_BEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    tx_vecs[1] = '{32'h0000_0000, {8'h00, 8'h00, 8'h00, 8'h00}};
    tx_vecs[2] = '{32'hFFFF_FFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    tx_vecs[3] = '{32'h0102_0304, {8'h01, 8'h02, 8'h03, 8'h04}};

    reset = 1'b1; tx_full = 1'b0; cmd_ready = 1'b1; tx_word_valid = 1'b0; tx_word = '0;
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("in_reset");
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    check("post_reset_tx_word_ready", tx_word_ready, 1'b1);
    check("post_reset_cmd_code", cmd_code, 8'h00);
    check("post_reset_cmd_arg", cmd_arg, 32'h0);

    // Command table, one frame at a time, then all frames queued back-to-back.
    for (int i = 0; i < 6; i++) begin
      tick();
      send_cmd(rx_vecs[i]);
      wait_rx_drain("rx_vec_drain");
    end
    tick();
    for (int i = 0; i < 6; i++) send_cmd(rx_vecs[i]);
    wait_rx_drain("rx_burst_drain");

    // Opcode only; handshake drops cmd_valid the next cycle.
    tick();
    send_cmd(rx_vecs[0]);
    wait_cmd_valid("op_only_valid");
    @(negedge clk);
    check("op_only_valid_drop", cmd_valid, 1'b0);
    wait_rx_drain("op_only_drain");

    // Pre-loaded 5-byte frame: five consecutive pops, cmd_valid five cycles after first.
    tick();
    send_cmd(rx_vecs[1]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b2b_rd_uart", rd_uart, (i < 5));
      check("b2b_cmd_valid", cmd_valid, (i == 5));
    end
    wait_rx_drain("b2b_drain");

    // Back-pressure: 0x02 stays queued while 0x01 is held.
    tick();
    cmd_ready = 1'b0;
    send_cmd('{8'h01, 32'h0, 8'h01, 32'h0});
    send_cmd('{8'h02, 32'h0, 8'h02, 32'h0});
    wait_cmd_valid("hold_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_rd_uart", rd_uart, 1'b0);
      check("hold_cmd_valid", cmd_valid, 1'b1);
      check("hold_cmd_code", cmd_code, 8'h01);
    end
    check("hold_fifo_level", rx_fifo.size(), 1);
    tick();
    cmd_ready = 1'b1;
    @(negedge clk);
    check("hold_release_no_pop", rd_uart, 1'b0);
    @(negedge clk);
    check("hold_next_pop", rd_uart, 1'b1);
    check("hold_next_byte", r_data, 8'h02);
    wait_rx_drain("hold_drain");

    // Reset mid-frame discards the partial argument and blocks pops while asserted.
    tick();
    push_bytes(8'h81, 32'h0, 1'b0);
    rx_fifo.push_back(8'hAA);
    repeat (5) tick();
    reset = 1'b1;
    send_cmd(rx_vecs[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("rx_reset");
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rx_reset_cmd_arg", cmd_arg, 32'h0);
    check("rx_reset_tx_word_ready", tx_word_ready, 1'b1);
    wait_rx_drain("rx_reset_drain");

    // TX word table.
    for (int i = 0; i < 4; i++) begin
      tick();
      send_word(tx_vecs[i]);
      wait_tx_drain("tx_vec_drain");
    end

    // DEADBEEF timing: four consecutive pushes, ready low throughout.
    tick();
    tx_word = 32'hDEAD_BEEF;
    tx_word_valid = 1'b1;
    @(negedge clk);
    check("tx_seq_accept", tx_word_ready, 1'b1);
    for (int i = 0; i < 4; i++) tx_exp.push_back(tx_vecs[0].exp_b[i]);
    tick();
    tx_word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tx_seq_wr_uart", wr_uart, 1'b1);
      check("tx_seq_ready_low", tx_word_ready, 1'b0);
    end
    @(negedge clk);
    check("tx_seq_ready_back", tx_word_ready, 1'b1);
    check("tx_seq_wr_done", wr_uart, 1'b0);

    // tx_full stall after the second byte.
    tick();
    send_word(tx_vecs[0]);
    @(negedge clk);
    @(negedge clk);
    tick();
    tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_w_data", w_data, 8'hAD);
      check("stall_wr_uart", wr_uart, 1'b0);
      check("stall_ready", tx_word_ready, 1'b0);
    end
    push0 = tx_push_cnt;
    tick();
    tx_full = 1'b0;
    wait_tx_drain("stall_drain");
    repeat (3) tick();
    check("stall_push_count", tx_push_cnt - push0, 2);

    // Reset mid-word abandons the remaining bytes.
    tick();
    send_word('{32'h1122_3344, {8'h11, 8'h22, 8'h33, 8'h44}});
    @(negedge clk);
    tick();
    tx_full = 1'b1;
    reset = 1'b1;
    tx_exp.delete();
    repeat (2) tick();
    tx_full = 1'b0;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wr_uart || !tx_word_ready) bad++;
    end
    check("tx_reset_abandon", bad, 0);

`ifdef UART_CMD_TIMEOUT_EN
    // Partial argument followed by silence times out; next opcode decodes normally.
    tick();
    push_bytes(8'h80, 32'h0, 1'b0);
    rx_fifo.push_back(8'h11);
    p = -1;
    for (int i = 0; i < 20 && p < 0; i++) begin
      @(negedge clk);
      if (rd_uart && r_data == 8'h11) p = int'(cyc);
    end
    check("to_last_pop_seen", (p >= 0), 1'b1);
    t = -1; pulses = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_timeout) begin
        pulses++;
        if (t < 0) t = int'(cyc);
      end
      if (cmd_valid) bad++;
    end
    check("to_latency", t - p, 16);
    check("to_pulse_count", pulses, 1);
    check("to_no_cmd_valid", bad, 0);
    tick();
    send_cmd('{8'h03, 32'h0, 8'h03, 32'h0});
    wait_rx_drain("to_recover_drain");
`else
    // Without the timeout the partial frame waits indefinitely, then completes.
    tick();
    push_bytes(8'h80, 32'h0, 1'b0);
    rx_fifo.push_back(8'h11);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_timeout || cmd_valid) bad++;
    end
    check("no_to_waits", bad, 0);
    tick();
    rx_fifo.push_back(8'h22);
    rx_fifo.push_back(8'h33);
    rx_fifo.push_back(8'h44);
    rx_exp.push_back({8'h80, 32'h4433_2211});
    wait_rx_drain("no_to_complete_drain");
    t = 0; p = 0; pulses = 0;
`endif

    repeat (3) tick();
    check("final_rx_exp_empty", rx_exp.size(), 0);
    check("final_tx_exp_empty", tx_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
